mprj_seq_monitor: RTL
=====================

# mprj_seq_monitor

Parametrised, synthesisable sequence monitor for user-project I/O. It watches a WIDTH-bit probe bus, typically a slice of `mprj_io`, for an ordered list of up to STEPS masked patterns. Each pattern must hold for HOLD cycles and be reached within a per-step cycle budget. It reports pass/fail, the current step and the failing step, replacing hand-written wait-for-value checks with one reusable on-chip or bench-side checker.

## Interface
- WIDTH, 16, probe bus width (1..32)
- STEPS, 4, depth of the step table (2..16)
- HOLD, 1, consecutive matching cycles required to accept a step (1..255)
- TMO_W, 24, width of per-step timeout counters
- SYNC, 2, probe synchroniser stages (0 = probe already synchronous)
- SW = $clog2(STEPS), step index width

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous reset, active-high
- probe  in  WIDTH  observed bus
- cfg_we  in  1  write step-table entry at cfg_addr (ignored while busy)
- cfg_addr  in  SW  step index
- cfg_value  in  WIDTH  expected pattern
- cfg_mask  in  WIDTH  compare mask (1 = bit compared)
- cfg_tmo  in  TMO_W  step budget in cycles; 0 = no timeout
- num_steps  in  SW+1  active steps, 1..STEPS; sampled at start; 0 or >STEPS treated as STEPS
- start  in  1  begin sequence (IDLE/PASS/FAIL only)
- abort  in  1  return to IDLE
- busy  out  1  high in RUN
- step_hit  out  1  one-cycle pulse when a step is accepted
- done  out  1  one-cycle pulse on entering PASS or FAIL
- pass  out  1  sticky until next start/abort/reset
- fail  out  1  sticky until next start/abort/reset
- cur_step  out  SW  step being awaited
- fail_step  out  SW  step that timed out

## Operation
- Step table: STEPS entries of {value, mask, tmo} registers; all zero at reset. A zero mask matches anything.
- Probe passes through SYNC flops, giving probe_s. match = ((probe_s ^ value[cur_step]) & mask[cur_step]) == 0.
- States: IDLE, RUN, PASS, FAIL.
- IDLE/PASS/FAIL + start → RUN. On entry: cur_step=0, hold_cnt=0, tmr=0, pass=fail=0, num_steps latched.
- RUN, each cycle:
  - hold_cnt increments on match and clears on mismatch.
  - When hold_cnt reaches HOLD-1 with match true, the step is accepted: step_hit=1, hold_cnt=0, tmr=0.
  - If the accepted step is the last active step, go to PASS. Otherwise cur_step+1.
  - If the step is not accepted, tmr increments. If tmo≠0 and tmr == tmo-1, go to FAIL with fail_step=cur_step.
- PASS/FAIL hold pass/fail and cur_step until start or abort.
- abort in any state → IDLE, clears pass/fail; the step table is kept.
- cfg_we is honoured in IDLE/PASS/FAIL only; a write during RUN is dropped.

## Timing
- Reset values: state IDLE, all outputs 0, table 0, synchroniser flops 0.
- start→busy: 1 cycle. Probe→compare latency: SYNC cycles.
- HOLD=1 with a matching probe_s: step_hit appears on the first matching cycle edge. A sequence of N pre-matching steps completes in N cycles after busy rises.
- Timeout budget: a step with tmo=T that never matches fails exactly T cycles after the step began. done and fail assert on the same edge.
- Acceptance and timeout in the same cycle: acceptance wins.
- start and abort in the same cycle: abort wins.
- start during RUN: ignored.
- Reset asserted mid-RUN: IDLE on the next edge, no done pulse.
- Counter saturation: tmr never wraps; with tmo=0 it saturates at all-ones.
- A write in the same cycle as start is applied, and the new entry is used by the sequence.

## Test plan
- WIDTH=16, SYNC=2, HOLD=1; steps AB40/FFFF, 0009/FFFF, AB51/FFFF, num_steps=3, tmo=1000. Drive the values in order, 50 cycles apart → three step_hit pulses, pass=1, done pulse, cur_step=2.
- Same table, probe stuck at AB40 after step 0 → fail=1 exactly 1000 cycles after step 1 starts (step 1 starts the cycle after step 0's step_hit), fail_step=1.
- HOLD=4, step 0 = 00A0/00F0. Probe shows 00A5 for 3 cycles then 0000 → no hit. Probe then shows 00AF for 4 cycles → step_hit on the 4th.
- Sequence in RUN, abort at step 1 → IDLE next cycle, busy=0, pass=fail=0. A cfg_we during the prior RUN left the table unchanged (read back via a rerun).
- tmo=0 on all steps, probe never matches for 2^TMO_W+10 cycles → no fail, busy stays 1.
- Timeout and match coincide (tmo=5, match arrives in the 5th cycle) → pass path, no fail. Reset pulsed mid-RUN → all outputs 0 next edge.

Source files
------------

// File: rtl/mprj_seq_monitor.sv
// mprj_seq_monitor
//   Watches a probe bus (typically a slice of mprj_io) for an ordered list of
//   masked patterns. Each pattern must hold for HOLD consecutive cycles and be
//   reached within its own cycle budget. Reports pass/fail, the step being
//   awaited and the step that timed out.
//
// Ports
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   probe                   observed bus (synchronised through SYNC flops)
//   cfg_we/cfg_addr/...     step-table write port, dropped while busy
//   num_steps               active step count, latched on start (0/>STEPS = STEPS)
//   start, abort            begin sequence / return to idle (abort wins)
//   busy                    sequence running
//   step_hit, done          one-cycle pulses on step acceptance / PASS-FAIL entry
//   pass, fail              sticky result until next start/abort/reset
//   cur_step, fail_step     step awaited / step that timed out
module mprj_seq_monitor #(
  parameter int WIDTH = 16,
  parameter int STEPS = 4,
  parameter int HOLD  = 1,
  parameter int TMO_W = 24,
  parameter int SYNC  = 2,
  localparam int SW   = $clog2(STEPS)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] probe,
  input  logic             cfg_we,
  input  logic [SW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_value,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [TMO_W-1:0] cfg_tmo,
  input  logic [SW:0]      num_steps,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             step_hit,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [SW-1:0]    cur_step,
  output logic [SW-1:0]    fail_step
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  localparam logic [7:0]    HOLD_LAST = 8'(HOLD - 1);
  localparam logic [SW:0]   STEPS_N   = (SW + 1)'(STEPS);
  localparam logic [SW-1:0] STEP_MAX  = SW'(STEPS - 1);

  // Probe synchroniser
  logic [WIDTH-1:0] probe_s;

  if (SYNC == 0) begin : g_nosync
    assign probe_s = probe;
  end else begin : g_sync
    logic [SYNC*WIDTH-1:0]     sync_q;
    logic [(SYNC+1)*WIDTH-1:0] sync_ext;

    // Oldest stage sits at the top of sync_ext; works for SYNC == 1 too.
    assign sync_ext = {sync_q, probe};
    assign probe_s  = sync_ext[(SYNC+1)*WIDTH-1 -: WIDTH];

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) sync_q <= '0;
      else          sync_q <= sync_ext[SYNC*WIDTH-1:0];
    end
  end

  // Step table and sequencer state
  logic [STEPS-1:0][WIDTH-1:0] tab_value, tab_mask;
  logic [STEPS-1:0][TMO_W-1:0] tab_tmo;

  state_t            state_q, state_d;
  logic [SW-1:0]     cur_q, cur_d, last_q, last_d, fstep_q, fstep_d;
  logic [7:0]        hold_q, hold_d;
  logic [TMO_W-1:0]  tmr_q, tmr_d, tmo_cur;
  logic              hit_q, hit_d, done_q, done_d;
  logic              match, accept, expired;
  logic [SW-1:0]     last_start;

  assign match      = ((probe_s ^ tab_value[cur_q]) & tab_mask[cur_q]) == '0;
  assign accept     = match && (hold_q == HOLD_LAST);
  assign tmo_cur    = tab_tmo[cur_q];
  assign expired    = (tmo_cur != '0) && (tmr_q == tmo_cur - 1'b1);
  assign last_start = (num_steps == '0 || num_steps > STEPS_N) ? STEP_MAX
                                                               : SW'(num_steps - 1'b1);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    fstep_d = fstep_q;
    hold_d  = hold_q;
    tmr_d   = tmr_q;
    hit_d   = 1'b0;
    done_d  = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      cur_d   = '0;
      fstep_d = '0;
      hold_d  = '0;
      tmr_d   = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          hold_d = match ? hold_q + 8'd1 : 8'd0;
          // Acceptance takes priority over a timeout in the same cycle.
          if (accept) begin
            hit_d  = 1'b1;
            hold_d = '0;
            tmr_d  = '0;
            if (cur_q == last_q) begin
              state_d = S_PASS;
              done_d  = 1'b1;
            end else begin
              cur_d = cur_q + 1'b1;
            end
          end else if (expired) begin
            state_d = S_FAIL;
            done_d  = 1'b1;
            fstep_d = cur_q;
          end else if (tmr_q != '1) begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: begin
          if (start) begin
            state_d = S_RUN;
            cur_d   = '0;
            fstep_d = '0;
            hold_d  = '0;
            tmr_d   = '0;
            last_d  = last_start;
          end
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      last_q    <= '0;
      fstep_q   <= '0;
      hold_q    <= '0;
      tmr_q     <= '0;
      hit_q     <= 1'b0;
      done_q    <= 1'b0;
      tab_value <= '0;
      tab_mask  <= '0;
      tab_tmo   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      fstep_q <= fstep_d;
      hold_q  <= hold_d;
      tmr_q   <= tmr_d;
      hit_q   <= hit_d;
      done_q  <= done_d;
      if (cfg_we && state_q != S_RUN) begin
        tab_value[cfg_addr] <= cfg_value;
        tab_mask[cfg_addr]  <= cfg_mask;
        tab_tmo[cfg_addr]   <= cfg_tmo;
      end
    end
  end

  assign busy      = (state_q == S_RUN);
  assign pass      = (state_q == S_PASS);
  assign fail      = (state_q == S_FAIL);
  assign step_hit  = hit_q;
  assign done      = done_q;
  assign cur_step  = cur_q;
  assign fail_step = fstep_q;

endmodule
